// File: rtl/uart_pkg.sv
// Shared encodings, FIFO entry layout and config helpers for the extended UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_t;

  typedef enum logic [1:0] {
    STOP_1   = 2'd0,
    STOP_1P5 = 2'd1,
    STOP_2   = 2'd2
  } stop_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  // Status bits sit directly above the data field of a FIFO entry.
  localparam int unsigned ENT_PERR_OFS = 0;
  localparam int unsigned ENT_FERR_OFS = 1;
  localparam int unsigned ENT_BRK_OFS  = 2;

  function automatic parity_t norm_parity(input logic [1:0] p);
    return (p == 2'd3) ? PAR_NONE : parity_t'(p);
  endfunction

  function automatic stop_t norm_stop(input logic [1:0] s);
    return s[1] ? STOP_2 : stop_t'(s);
  endfunction

  function automatic logic [3:0] clamp_bits(input logic [3:0] b, input logic [3:0] max_bits);
    if (b < 4'd5) return 4'd5;
    if (b > max_bits) return max_bits;
    return b;
  endfunction

endpackage

// File: rtl/dsync.sv
// Two-flop synchroniser for a single asynchronous bit.
module dsync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/majority3.sv
// Three-input majority vote.
module majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; a push while full is dropped unless a pop frees a slot the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is masked while empty so stale storage never reaches the outputs.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push && !do_push;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime frame format, parity/framing/break status and an RX FIFO.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int unsigned MAX_WIDTH   = 9,
  parameter int unsigned SAMPLE_RATE = 16,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_rx,
  input  logic [15:0]              clk_div,
  input  logic [3:0]               cfg_data_bits,
  input  logic [1:0]               cfg_parity,
  input  logic [1:0]               cfg_stop_bits,
  output logic [MAX_WIDTH-1:0]     rx_data,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err,
  output logic                     rx_break,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_level,
  output logic                     overrun,
  output logic                     rx_busy
);
  localparam int unsigned TW   = $clog2(SAMPLE_RATE) + 1;
  localparam int unsigned EW   = MAX_WIDTH + 3;
  localparam logic [TW-1:0] HALF = TW'(SAMPLE_RATE / 2);
  localparam logic [TW-1:0] FULL = TW'(SAMPLE_RATE);

  logic [15:0] div_cnt;
  logic        tick;

  assign tick = (div_cnt == clk_div);

  always_ff @(posedge clk) begin
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + 16'd1;
  end

  logic       rx_sync, filt;
  logic [2:0] hist;

  dsync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(uart_rx), .q(rx_sync));

  always_ff @(posedge clk) begin
    if (rst) hist <= '1;
    else     hist <= {hist[1:0], rx_sync};
  end

  majority3 u_maj (.a(hist[0]), .b(hist[1]), .c(hist[2]), .y(filt));

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d, tcnt_inc, stop_target;
  logic [3:0]           bcnt_q, bcnt_d, nbits_q, nbits_d;
  logic [MAX_WIDTH-1:0] data_q, data_d;
  parity_t              par_q, par_d;
  stop_t                stop_q, stop_d;
  logic par_acc_q, par_acc_d, par_bit_q, par_bit_d, perr_q, perr_d;
  logic ferr_q, ferr_d, brk_q, brk_d, stop_ph_q, stop_ph_d, brk_wait_q, brk_wait_d;
  logic push;

  assign tcnt_inc    = tcnt_q + 1'b1;
  assign stop_target = (stop_ph_q && stop_q == STOP_1P5) ? HALF : FULL;

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    nbits_d    = nbits_q;
    data_d     = data_q;
    par_d      = par_q;
    stop_d     = stop_q;
    par_acc_d  = par_acc_q;
    par_bit_d  = par_bit_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    stop_ph_d  = stop_ph_q;
    brk_wait_d = brk_wait_q;
    push       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (brk_wait_q) begin
          if (filt) brk_wait_d = 1'b0;
        end else if (!filt) begin
          state_d   = S_START;
          tcnt_d    = '0;
          bcnt_d    = '0;
          data_d    = '0;
          par_acc_d = 1'b0;
          par_bit_d = 1'b0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
          brk_d     = 1'b0;
          stop_ph_d = 1'b0;
          nbits_d   = clamp_bits(cfg_data_bits, 4'(MAX_WIDTH));
          par_d     = norm_parity(cfg_parity);
          stop_d    = norm_stop(cfg_stop_bits);
        end
      end
      S_START: begin
        if (filt) state_d = S_IDLE;
        else if (tick) begin
          if (tcnt_inc == HALF) begin
            state_d = S_DATA;
            tcnt_d  = '0;
          end else tcnt_d = tcnt_inc;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_inc == FULL) begin
            tcnt_d    = '0;
            data_d    = data_q | (MAX_WIDTH'(filt) << bcnt_q);
            par_acc_d = par_acc_q ^ filt;
            if (bcnt_q == nbits_q - 4'd1) state_d = (par_q == PAR_NONE) ? S_STOP : S_PARITY;
            else bcnt_d = bcnt_q + 4'd1;
          end else tcnt_d = tcnt_inc;
        end
      end
      S_PARITY: begin
        if (tick) begin
          if (tcnt_inc == FULL) begin
            tcnt_d    = '0;
            par_bit_d = filt;
            perr_d    = par_acc_q ^ filt ^ (par_q == PAR_ODD);
            state_d   = S_STOP;
          end else tcnt_d = tcnt_inc;
        end
      end
      S_STOP: begin
        // Phase 0 checks the first stop bit; phase 1 is the 2nd bit or the extra half bit.
        if (tick) begin
          if (tcnt_inc == stop_target) begin
            tcnt_d = '0;
            if (!stop_ph_q) begin
              ferr_d = !filt;
              brk_d  = (data_q == '0) && !par_bit_q && !filt;
              if (stop_q == STOP_1) push = 1'b1;
              else stop_ph_d = 1'b1;
            end else begin
              if (stop_q == STOP_2) ferr_d = ferr_q | !filt;
              push = 1'b1;
            end
          end else tcnt_d = tcnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (push) begin
      state_d    = S_IDLE;
      brk_wait_d = brk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      nbits_q    <= '0;
      data_q     <= '0;
      par_q      <= PAR_NONE;
      stop_q     <= STOP_1;
      par_acc_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      stop_ph_q  <= 1'b0;
      brk_wait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      nbits_q    <= nbits_d;
      data_q     <= data_d;
      par_q      <= par_d;
      stop_q     <= stop_d;
      par_acc_q  <= par_acc_d;
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      stop_ph_q  <= stop_ph_d;
      brk_wait_q <= brk_wait_d;
    end
  end

  logic [EW-1:0] entry, head;
  logic          fifo_empty;

  assign entry = {brk_d, ferr_d, perr_q, data_q};

  uart_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wdata   (entry),
    .pop     (rx_ready),
    .rdata   (head),
    .empty   (fifo_empty),
    .level   (rx_level),
    .overrun (overrun)
  );

  assign rx_valid      = !fifo_empty;
  assign rx_data       = head[MAX_WIDTH-1:0];
  assign rx_parity_err = head[MAX_WIDTH + ENT_PERR_OFS];
  assign rx_frame_err  = head[MAX_WIDTH + ENT_FERR_OFS];
  assign rx_break      = head[MAX_WIDTH + ENT_BRK_OFS];
  assign rx_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_ext.sv
// Self-checking bench for uart_rx_ext: frames are generated at bit level and checked against a frame-rule model.
module tb_uart_rx_ext;
  localparam int unsigned MW = 9;
  localparam int unsigned SR = 16;
  localparam int unsigned DP = 4;

  logic                 clk = 1'b0;
  logic                 rst, uart_rx, rx_ready;
  logic [15:0]          clk_div;
  logic [3:0]           cfg_data_bits;
  logic [1:0]           cfg_parity, cfg_stop_bits;
  logic [MW-1:0]        rx_data;
  logic                 rx_parity_err, rx_frame_err, rx_break, rx_valid, overrun, rx_busy;
  logic [$clog2(DP):0]  rx_level;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_ext #(.MAX_WIDTH(MW), .SAMPLE_RATE(SR), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .clk_div(clk_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop_bits(cfg_stop_bits),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
    .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  function automatic int bit_clks();
    return (int'(clk_div) + 1) * SR;
  endfunction

  function automatic int eff_bits(input logic [3:0] c);
    if (c < 5) return 5;
    if (c > MW) return MW;
    return int'(c);
  endfunction

  // par: 0 none, 1 odd, 2 even. Parity bit makes the total count of ones odd/even; flip corrupts it.
  function automatic logic par_bit(input logic [MW-1:0] d, input int nb, input int par, input bit flip);
    int ones;
    ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(d[i]);
    return (((ones % 2) == 1) != (par == 1)) ^ flip;
  endfunction

  // Entry = {break, frame_err, parity_err, data}; stopc: 0 = 1, 1 = 1.5, 2 = 2 stop bits.
  function automatic logic [MW+2:0] model_entry(input logic [MW-1:0] d, input int nb, input int par,
                                                input bit flip, input int stopc, input bit s2low);
    logic [MW-1:0] m;
    logic pb, perr, ferr;
    int ones;
    m    = d & MW'((1 << nb) - 1);
    pb   = par_bit(d, nb, par, flip);
    ones = $countones(m);
    perr = (par == 1 || par == 2) && (((ones + int'(pb)) % 2) != ((par == 1) ? 1 : 0));
    ferr = (stopc == 2) && s2low;
    return {1'b0, ferr, perr, m};
  endfunction

  task automatic drive(input logic v, input int n);
    uart_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [MW-1:0] d, input int nb, input int par, input bit flip,
                            input int stopc, input bit s2low);
    int b;
    b = bit_clks();
    drive(1'b0, b);
    for (int i = 0; i < nb; i++) drive(d[i], b);
    if (par == 1 || par == 2) drive(par_bit(d, nb, par, flip), b);
    drive(1'b1, b);
    if (stopc == 1) drive(1'b1, b / 2);
    else if (stopc == 2) begin
      // A low second stop bit is released early so it cannot look like a new start bit.
      if (s2low) begin drive(1'b0, 3 * b / 4); drive(1'b1, b / 4); end
      else drive(1'b1, b);
    end
    drive(1'b1, 2 * b);
  endtask

  task automatic pop_one(output logic [MW+2:0] e, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (rx_valid) ok = 1'b1;
      else @(negedge clk);
    end
    e = {rx_break, rx_frame_err, rx_parity_err, rx_data};
    if (ok) begin
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic [1:0] stp);
    cfg_data_bits = nb; cfg_parity = par; cfg_stop_bits = stp;
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; clk_div = 16'd3;
    set_cfg(4'd8, 2'd0, 2'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_level !== '0) begin n_fail++; $display("FAIL reset_level got %0d want 0", rx_level); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++;
    if ({rx_break, rx_frame_err, rx_parity_err, rx_data} !== '0) begin
      n_fail++; $display("FAIL reset_head got %h want 0", {rx_break, rx_frame_err, rx_parity_err, rx_data});
    end
  endtask

  task automatic test_8n1_stream();
    int lvl1, nval;
    logic [MW+2:0] got, exp;
    lvl1 = 0; nval = 0; got = '0;
    set_cfg(4'd8, 2'd0, 2'd0);
    exp = model_entry(9'h0A5, 8, 0, 1'b0, 0, 1'b0);
    rx_ready = 1'b1;
    fork
      send_frame(9'h0A5, 8, 0, 1'b0, 0, 1'b0);
      repeat (12 * bit_clks()) begin
        @(negedge clk);
        if (rx_level == 1) lvl1++;
        if (rx_valid) begin nval++; got = {rx_break, rx_frame_err, rx_parity_err, rx_data}; end
      end
    join
    rx_ready = 1'b0;
    n_checks++; if (nval !== 1) begin n_fail++; $display("FAIL a5_valid_cycles got %0d want 1", nval); end
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL a5_entry got %h want %h", got, exp); end
    n_checks++; if (lvl1 !== 1) begin n_fail++; $display("FAIL a5_level_pulse got %0d want 1", lvl1); end
    n_checks++; if (rx_level !== '0) begin n_fail++; $display("FAIL a5_level_end got %0d want 0", rx_level); end
  endtask

  task automatic test_random_frames();
    logic [3:0] rnb; logic [1:0] rpar, rstp;
    logic [MW-1:0] d; bit flip, s2low, ok;
    int nb, par, stopc;
    logic [MW+2:0] got, exp;
    for (int k = 0; k < 8; k++) begin
      rnb = 4'($urandom_range(0, 15)); rpar = 2'($urandom_range(0, 3)); rstp = 2'($urandom_range(0, 3));
      d = MW'($urandom); flip = 1'($urandom_range(0, 1)); s2low = 1'($urandom_range(0, 1));
      set_cfg(rnb, rpar, rstp);
      nb = eff_bits(rnb);
      par = (rpar == 2'd3) ? 0 : int'(rpar);
      stopc = (rstp >= 2'd2) ? 2 : int'(rstp);
      exp = model_entry(d, nb, par, flip, stopc, s2low);
      send_frame(d, nb, par, flip, stopc, s2low);
      pop_one(got, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout got no entry want one", k); end
      n_checks++;
      if (got !== exp) begin
        n_fail++; $display("FAIL rand%0d_entry cfg=%0d/%0d/%0d got %h want %h", k, rnb, rpar, rstp, got, exp);
      end
    end
  endtask

  task automatic test_parity_7e1();
    logic [MW+2:0] got; bit ok;
    set_cfg(4'd7, 2'd2, 2'd0);
    send_frame(9'h041, 7, 2, 1'b0, 0, 1'b0);
    send_frame(9'h041, 7, 2, 1'b1, 0, 1'b0);
    pop_one(got, ok);
    n_checks++; if (got !== {3'b000, 9'h041}) begin n_fail++; $display("FAIL 7e1_good got %h want %h", got, {3'b000, 9'h041}); end
    pop_one(got, ok);
    n_checks++; if (got !== {3'b001, 9'h041}) begin n_fail++; $display("FAIL 7e1_bad got %h want %h", got, {3'b001, 9'h041}); end
  endtask

  task automatic test_frame_err_8n2();
    logic [MW+2:0] got; bit ok;
    set_cfg(4'd8, 2'd0, 2'd2);
    send_frame(9'h03C, 8, 0, 1'b0, 2, 1'b1);
    pop_one(got, ok);
    n_checks++; if (got !== {3'b010, 9'h03C}) begin n_fail++; $display("FAIL 8n2_ferr got %h want %h", got, {3'b010, 9'h03C}); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL 8n2_extra got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_break();
    logic [MW+2:0] got, exp; bit ok;
    set_cfg(4'd8, 2'd0, 2'd0);
    drive(1'b0, 11 * bit_clks());
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL brk_busy got %b want 0", rx_busy); end
    n_checks++; if (rx_level !== 1) begin n_fail++; $display("FAIL brk_level11 got %0d want 1", rx_level); end
    drive(1'b0, bit_clks());
    drive(1'b1, 2 * bit_clks());
    n_checks++; if (rx_level !== 1) begin n_fail++; $display("FAIL brk_level_after got %0d want 1", rx_level); end
    pop_one(got, ok);
    n_checks++; if (got !== {3'b110, 9'h000}) begin n_fail++; $display("FAIL brk_entry got %h want %h", got, {3'b110, 9'h000}); end
    exp = model_entry(9'h05A, 8, 0, 1'b0, 0, 1'b0);
    send_frame(9'h05A, 8, 0, 1'b0, 0, 1'b0);
    pop_one(got, ok);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL brk_next got %h want %h", got, exp); end
  endtask

  task automatic test_glitch();
    logic [MW+2:0] got, exp; bit ok;
    set_cfg(4'd8, 2'd0, 2'd0);
    drive(1'b0, 4 * (int'(clk_div) + 1));
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start got busy=%b want 1", rx_busy); end
    drive(1'b1, 2 * bit_clks());
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b want 0", rx_busy); end
    n_checks++; if (rx_level !== '0) begin n_fail++; $display("FAIL glitch_level got %0d want 0", rx_level); end
    exp = model_entry(9'h055, 8, 0, 1'b0, 0, 1'b0);
    send_frame(9'h055, 8, 0, 1'b0, 0, 1'b0);
    pop_one(got, ok);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL glitch_next got %h want %h", got, exp); end
  endtask

  task automatic test_overrun();
    int ovr; bit done, ok;
    logic [MW+2:0] got;
    ovr = 0; done = 1'b0;
    set_cfg(4'd8, 2'd0, 2'd0);
    fork
      begin
        for (int k = 1; k <= 5; k++) send_frame(MW'(k), 8, 0, 1'b0, 0, 1'b0);
        done = 1'b1;
      end
      while (!done) begin
        @(negedge clk);
        if (overrun) ovr++;
      end
    join
    n_checks++; if (rx_level !== DP) begin n_fail++; $display("FAIL ovr_level got %0d want %0d", rx_level, DP); end
    n_checks++; if (ovr !== 1) begin n_fail++; $display("FAIL ovr_pulses got %0d want 1", ovr); end
    for (int k = 1; k <= 4; k++) begin
      pop_one(got, ok);
      n_checks++; if (got !== {3'b000, MW'(k)}) begin n_fail++; $display("FAIL ovr_pop%0d got %h want %h", k, got, {3'b000, MW'(k)}); end
    end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got valid=%b want 0", rx_valid); end
  endtask

  task automatic test_cfg_change();
    logic [MW+2:0] got, exp; bit ok;
    set_cfg(4'd8, 2'd0, 2'd0);
    exp = model_entry(9'h0E3, 8, 0, 1'b0, 0, 1'b0);
    fork
      send_frame(9'h0E3, 8, 0, 1'b0, 0, 1'b0);
      begin repeat (3 * bit_clks()) @(negedge clk); cfg_data_bits = 4'd5; end
    join
    pop_one(got, ok);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL cfg_cur got %h want %h", got, exp); end
    send_frame(9'h0FF, 5, 0, 1'b0, 0, 1'b0);
    pop_one(got, ok);
    n_checks++; if (got !== {3'b000, 9'h01F}) begin n_fail++; $display("FAIL cfg_next got %h want %h", got, {3'b000, 9'h01F}); end
  endtask

  task automatic test_reset_mid();
    logic [MW+2:0] got, exp; bit ok;
    set_cfg(4'd8, 2'd0, 2'd0);
    send_frame(9'h096, 8, 0, 1'b0, 0, 1'b0);
    n_checks++; if (rx_level !== 1) begin n_fail++; $display("FAIL rmid_pre_level got %0d want 1", rx_level); end
    drive(1'b0, 3 * bit_clks());
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy got %b want 1", rx_busy); end
    rst = 1'b1; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", rx_valid); end
    n_checks++; if (rx_level !== '0) begin n_fail++; $display("FAIL rmid_level got %0d want 0", rx_level); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got busy=%b want 0", rx_busy); end
    drive(1'b1, 2 * bit_clks());
    exp = model_entry(9'h13A, 9, 1, 1'b0, 1, 1'b0);
    set_cfg(4'd9, 2'd1, 2'd1);
    send_frame(9'h13A, 9, 1, 1'b0, 1, 1'b0);
    pop_one(got, ok);
    n_checks++; if (got !== exp) begin n_fail++; $display("FAIL rmid_after got %h want %h", got, exp); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_8n1_stream();
    test_random_frames();
    test_parity_7e1();
    test_frame_err_8n2();
    test_break();
    test_glitch();
    test_overrun();
    test_cfg_change();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
